// File: rtl/cntr_updn_mod_if.sv
// ---------------------------------------------------------------------------
// cntr_updn_mod_if
// Control/status bundle for the up/down modulo counter.
//
// Signals:
//   enbl      count enable (freezes counter and prescaler when low)
//   up_dn     direction, 1 = up, 0 = down
//   clr       synchronous clear
//   load      synchronous parallel load
//   load_val  value for load (clamped to MOD_MAX by the counter)
//   cntr      current count
//   tc        one-cycle terminal-count pulse
//   ovf       sticky boundary-event flag
//
// Modports:
//   master  drives the controls, observes the count (user / bench side)
//   slave   the counter itself
//
// There is no valid/ready handshake: every control is level-sampled on each
// rising clk edge, and every status output is registered.
// ---------------------------------------------------------------------------
interface cntr_updn_mod_if #(
  parameter int WIDTH = 3
);
  logic             enbl;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cntr;
  logic             tc;
  logic             ovf;

  modport master (
    output enbl, up_dn, clr, load, load_val,
    input  cntr, tc, ovf
  );

  modport slave (
    input  enbl, up_dn, clr, load, load_val,
    output cntr, tc, ovf
  );
endinterface

// File: rtl/cntr_updn_mod.sv
// ---------------------------------------------------------------------------
// cntr_updn_mod
// Parametrised up/down modulo counter (range 0..MOD_MAX) with synchronous
// clear, clamped parallel load, prescaled stepping, a one-cycle terminal-count
// pulse and a sticky overflow flag.
//
// Parameters:
//   WIDTH     counter width in bits (1..32)
//   MOD_MAX   terminal value, must fit in WIDTH bits
//   PRESCALE  enabled cycles per count step (1..256)
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   cntr_updn_mod_if.slave (enbl, up_dn, clr, load, load_val in;
//         cntr, tc, ovf out)
//
// Configuration macro:
//   CNTR_SAT_EN  when defined, a step at the boundary holds the count
//                (MOD_MAX going up, 0 going down) instead of wrapping.
//                tc and ovf behave identically in both builds.
//
// Edge priority: rst > clr > load > step.
// ---------------------------------------------------------------------------
module cntr_updn_mod #(
  parameter int          WIDTH    = 3,
  parameter int unsigned MOD_MAX  = 7,
  parameter int          PRESCALE = 1
) (
  input logic             clk,
  input logic             rst,
  cntr_updn_mod_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [PW-1:0]    PSC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PSC_ONE  = PW'(1);

  logic [WIDTH-1:0] r_cntr;
  logic             r_tc;
  logic             r_ovf;
  logic [PW-1:0]    r_psc;

  logic             w_tick;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_bound;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_cntr_step;

  // A tick is the enabled cycle that completes a prescale period; with
  // PRESCALE=1 the prescaler is pinned at 0 and every enabled cycle ticks.
  assign w_tick   = bus.enbl && (r_psc == PSC_LAST);
  assign w_at_top = (r_cntr == MAX_V);
  assign w_at_bot = (r_cntr == '0);

  // Boundary event: a step attempted from the end the direction points at.
  assign w_bound  = w_tick && (bus.up_dn ? w_at_top : w_at_bot);

  assign w_load_clamped = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;

  // Value the counter takes on a tick.
  always_comb begin
    w_cntr_step = r_cntr;
    if (bus.up_dn) begin
      if (w_at_top) begin
`ifdef CNTR_SAT_EN
        w_cntr_step = MAX_V;
`else
        w_cntr_step = '0;
`endif
      end else begin
        w_cntr_step = r_cntr + CNT_ONE;
      end
    end else begin
      if (w_at_bot) begin
`ifdef CNTR_SAT_EN
        w_cntr_step = '0;
`else
        w_cntr_step = MAX_V;
`endif
      end else begin
        w_cntr_step = r_cntr - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cntr <= '0;
      r_tc   <= 1'b0;
      r_ovf  <= 1'b0;
      r_psc  <= '0;
    end else if (bus.clr) begin
      r_cntr <= '0;
      r_tc   <= 1'b0;
      r_ovf  <= 1'b0;
      r_psc  <= '0;
    end else if (bus.load) begin
      // ovf is deliberately left alone: load repositions, it does not
      // acknowledge a past boundary event.
      r_cntr <= w_load_clamped;
      r_tc   <= 1'b0;
      r_psc  <= '0;
    end else begin
      if (bus.enbl) begin
        r_psc <= w_tick ? '0 : (r_psc + PSC_ONE);
      end
      if (w_tick) begin
        r_cntr <= w_cntr_step;
      end
      r_tc <= w_bound;
      if (w_bound) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.cntr = r_cntr;
  assign bus.tc   = r_tc;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_cntr_updn_mod.sv
// ---------------------------------------------------------------------------
// tb_cntr_updn_mod
// Three counter instances:
//   dut0  WIDTH=3 MOD_MAX=5 PRESCALE=1  wrap/saturate, direction, load, clr
//   dut1  WIDTH=3 MOD_MAX=7 PRESCALE=3  prescaler/enable, async reset mid-count
//   dut2  WIDTH=1 MOD_MAX=0 PRESCALE=1  back-to-back boundary events
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_cntr_updn_mod;

  localparam int SBW = 5;  // {cntr[2:0], tc, ovf} of dut0

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  cntr_updn_mod_if #(.WIDTH(3)) if0 ();
  cntr_updn_mod_if #(.WIDTH(3)) if1 ();
  cntr_updn_mod_if #(.WIDTH(1)) if2 ();

  cntr_updn_mod #(.WIDTH(3), .MOD_MAX(5), .PRESCALE(1)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  cntr_updn_mod #(.WIDTH(3), .MOD_MAX(7), .PRESCALE(3)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  cntr_updn_mod #(.WIDTH(1), .MOD_MAX(0), .PRESCALE(1)) dut2 (
    .clk(clk), .rst(rst), .bus(if2)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [SBW-1:0] exp_q[$];

  typedef struct {
    logic       en;
    logic       ud;
    logic       cl;
    logic       ld;
    logic [2:0] lv;
    logic [2:0] w_c;   // expected in wrap build
    logic       w_t;
    logic       w_o;
    logic [2:0] s_c;   // expected in saturating build
    logic       s_t;
    logic       s_o;
  } vec_t;

  vec_t tbl[25];

  // reference model state for the random phase on dut0
  logic [2:0] m_cntr;
  logic       m_tc;
  logic       m_ovf;

  function automatic vec_t mk(input int en, input int ud, input int cl, input int ld,
                              input int lv, input int wc, input int wt, input int wo,
                              input int sc, input int st, input int so);
    vec_t v;
    v.en  = en[0];
    v.ud  = ud[0];
    v.cl  = cl[0];
    v.ld  = ld[0];
    v.lv  = lv[2:0];
    v.w_c = wc[2:0];
    v.w_t = wt[0];
    v.w_o = wo[0];
    v.s_c = sc[2:0];
    v.s_t = st[0];
    v.s_o = so[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic score0(input string tag);
    logic [SBW-1:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard queue empty, got cntr=%0d", tag, if0.cntr);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".cntr"}, 32'(if0.cntr), 32'(e[4:2]));
      check({tag, ".tc"},   32'(if0.tc),   32'(e[1]));
      check({tag, ".ovf"},  32'(if0.ovf),  32'(e[0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive0(input logic en, input logic ud, input logic cl, input logic ld,
                        input logic [2:0] lv, input logic [SBW-1:0] exp, input string tag);
    if0.enbl     = en;
    if0.up_dn    = ud;
    if0.clr      = cl;
    if0.load     = ld;
    if0.load_val = lv;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    score0(tag);
  endtask

  task automatic drive1(input logic en, input logic cl, input logic ld, input logic [2:0] lv);
    if1.enbl     = en;
    if1.clr      = cl;
    if1.load     = ld;
    if1.load_val = lv;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference for dut0 (MOD_MAX=5, PRESCALE=1).
  task automatic model0(input logic en, input logic ud, input logic cl, input logic ld,
                        input logic [2:0] lv);
    logic edge_hit;
    if (cl) begin
      m_cntr = 3'd0;
      m_tc   = 1'b0;
      m_ovf  = 1'b0;
    end else if (ld) begin
      m_cntr = (lv > 3'd5) ? 3'd5 : lv;
      m_tc   = 1'b0;
    end else if (en) begin
      edge_hit = ud ? (m_cntr == 3'd5) : (m_cntr == 3'd0);
      m_tc     = edge_hit;
      if (edge_hit) m_ovf = 1'b1;
`ifdef CNTR_SAT_EN
      if (!edge_hit) m_cntr = ud ? (m_cntr + 3'd1) : (m_cntr - 3'd1);
`else
      if (ud) m_cntr = edge_hit ? 3'd0 : (m_cntr + 3'd1);
      else    m_cntr = edge_hit ? 3'd5 : (m_cntr - 3'd1);
`endif
    end else begin
      m_tc = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  logic       en_pat[7];
  logic [2:0] cnt_pat[7];
  logic       r_en, r_ud, r_cl, r_ld;
  logic [2:0] r_lv;
  logic [SBW-1:0] e;

  initial begin
    //          en ud cl ld lv | wrap c t o | sat c t o
    tbl[0]  = mk(1, 1, 0, 0, 0,   1, 0, 0,   1, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 0,   2, 0, 0,   2, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 0,   3, 0, 0,   3, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0, 0,   4, 0, 0,   4, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0, 0,   5, 0, 0,   5, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 0,   0, 1, 1,   5, 1, 1);
    tbl[6]  = mk(1, 1, 0, 0, 0,   1, 0, 1,   5, 1, 1);
    tbl[7]  = mk(1, 1, 1, 0, 0,   0, 0, 0,   0, 0, 0);
    tbl[8]  = mk(0, 1, 0, 1, 2,   2, 0, 0,   2, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0,   1, 0, 0,   1, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0,   5, 1, 1,   0, 1, 1);
    tbl[12] = mk(1, 1, 0, 0, 0,   0, 1, 1,   1, 0, 1);
    tbl[13] = mk(0, 1, 0, 0, 0,   0, 0, 1,   1, 0, 1);
    tbl[14] = mk(1, 1, 0, 1, 7,   5, 0, 1,   5, 0, 1);
    tbl[15] = mk(1, 1, 1, 1, 3,   0, 0, 0,   0, 0, 0);
    tbl[16] = mk(0, 1, 0, 1, 4,   4, 0, 0,   4, 0, 0);
    tbl[17] = mk(1, 1, 0, 0, 0,   5, 0, 0,   5, 0, 0);
    tbl[18] = mk(1, 1, 0, 0, 0,   0, 1, 1,   5, 1, 1);
    tbl[19] = mk(1, 1, 0, 0, 0,   1, 0, 1,   5, 1, 1);
    tbl[20] = mk(0, 1, 1, 0, 0,   0, 0, 0,   0, 0, 0);
    tbl[21] = mk(1, 0, 0, 0, 0,   5, 1, 1,   0, 1, 1);
    tbl[22] = mk(1, 0, 0, 0, 0,   4, 0, 1,   0, 1, 1);
    tbl[23] = mk(1, 0, 0, 1, 6,   5, 0, 1,   5, 0, 1);
    tbl[24] = mk(1, 1, 0, 0, 0,   0, 1, 1,   5, 1, 1);

    en_pat  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    cnt_pat = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2};

    // idle inputs, reset asserted
    rst = 1'b1;
    if0.enbl = 1'b0; if0.up_dn = 1'b1; if0.clr = 1'b0; if0.load = 1'b0; if0.load_val = 3'd0;
    if1.enbl = 1'b0; if1.up_dn = 1'b1; if1.clr = 1'b0; if1.load = 1'b0; if1.load_val = 3'd0;
    if2.enbl = 1'b0; if2.up_dn = 1'b1; if2.clr = 1'b0; if2.load = 1'b0; if2.load_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.cntr0", 32'(if0.cntr), 32'd0);
    check("reset.tc0",   32'(if0.tc),   32'd0);
    check("reset.ovf0",  32'(if0.ovf),  32'd0);
    check("reset.cntr1", 32'(if1.cntr), 32'd0);
    rst = 1'b0;

    // table-driven vectors on dut0
    for (int i = 0; i < 25; i++) begin
`ifdef CNTR_SAT_EN
      e = {tbl[i].s_c, tbl[i].s_t, tbl[i].s_o};
`else
      e = {tbl[i].w_c, tbl[i].w_t, tbl[i].w_o};
`endif
      drive0(tbl[i].en, tbl[i].ud, tbl[i].cl, tbl[i].ld, tbl[i].lv, e,
             $sformatf("vec%0d", i));
    end
    if0.enbl = 1'b0; if0.clr = 1'b0; if0.load = 1'b0;

    // dut2: MOD_MAX=0, every enabled cycle is a boundary event
    if2.enbl = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d.tc", k),   32'(if2.tc),   32'd1);
      check($sformatf("b2b%0d.cntr", k), 32'(if2.cntr), 32'd0);
      check($sformatf("b2b%0d.ovf", k),  32'(if2.ovf),  32'd1);
    end
    if2.enbl = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_stop.tc",  32'(if2.tc),  32'd0);
    check("b2b_stop.ovf", 32'(if2.ovf), 32'd1);

    // dut1: prescale 3, an enbl-low cycle must not advance the prescaler
    drive1(1'b0, 1'b1, 1'b0, 3'd0);
    check("psc_clr.cntr", 32'(if1.cntr), 32'd0);
    for (int k = 0; k < 7; k++) begin
      drive1(en_pat[k], 1'b0, 1'b0, 3'd0);
      check($sformatf("psc%0d.cntr", k), 32'(if1.cntr), 32'(cnt_pat[k]));
      check($sformatf("psc%0d.tc", k),   32'(if1.tc),   32'd0);
    end

    // dut1: load 5, run partway into a prescale period, then async reset
    drive1(1'b0, 1'b0, 1'b1, 3'd5);
    check("rst_mid.load", 32'(if1.cntr), 32'd5);
    drive1(1'b1, 1'b0, 1'b0, 3'd0);
    drive1(1'b1, 1'b0, 1'b0, 3'd0);
    check("rst_mid.pre_cntr", 32'(if1.cntr), 32'd5);
    check("rst_mid.pre_ovf0", 32'(if0.ovf),  32'd1);
    check("rst_mid.pre_ovf2", 32'(if2.ovf),  32'd1);
    #3;
    rst = 1'b1;
    #1;  // between edges: reset must act with no clk edge
    check("rst_async.cntr1", 32'(if1.cntr), 32'd0);
    check("rst_async.tc1",   32'(if1.tc),   32'd0);
    check("rst_async.ovf0",  32'(if0.ovf),  32'd0);
    check("rst_async.cntr0", 32'(if0.cntr), 32'd0);
    check("rst_async.ovf2",  32'(if2.ovf),  32'd0);
    @(posedge clk);
    #1;
    check("rst_hold.cntr1", 32'(if1.cntr), 32'd0);
    rst = 1'b0;
    // enbl still high: steps land on the 3rd and 6th edge after release
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_resume%0d.cntr", k), 32'(if1.cntr),
            (k < 3) ? 32'd0 : ((k < 6) ? 32'd1 : 32'd2));
    end
    if1.enbl = 1'b0;

    // random phase on dut0 against the reference model (dut0 is at reset state)
    m_cntr = 3'd0;
    m_tc   = 1'b0;
    m_ovf  = 1'b0;
    for (int i = 0; i < 150; i++) begin
      r_en = ($urandom_range(0, 3) != 0);
      r_ud = ($urandom_range(0, 1) == 1);
      r_cl = ($urandom_range(0, 19) == 0);
      r_ld = ($urandom_range(0, 9) == 0);
      r_lv = 3'($urandom_range(0, 7));
      model0(r_en, r_ud, r_cl, r_ld, r_lv);
      drive0(r_en, r_ud, r_cl, r_ld, r_lv, {m_cntr, m_tc, m_ovf}, $sformatf("rnd%0d", i));
    end

    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
